// File: rtl/reg_file_if.sv
// rtl/reg_file_if.sv - read/write port bundle for the two-read, one-write register file
interface reg_file_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5
);
  logic [ADDR_WIDTH-1:0] i_raddr1;
  logic [ADDR_WIDTH-1:0] i_raddr2;
  logic [ADDR_WIDTH-1:0] i_waddr;
  logic [DATA_WIDTH-1:0] i_wdata;
  logic                  i_we;
  logic [DATA_WIDTH-1:0] o_rdata1;
  logic [DATA_WIDTH-1:0] o_rdata2;

  modport master (
    output i_raddr1, i_raddr2, i_waddr, i_wdata, i_we,
    input  o_rdata1, o_rdata2
  );

  modport slave (
    input  i_raddr1, i_raddr2, i_waddr, i_wdata, i_we,
    output o_rdata1, o_rdata2
  );
endinterface

// File: rtl/reg_file.sv
// rtl/reg_file.sv - 2**ADDR_WIDTH x DATA_WIDTH register file, r0 hard-wired to zero, write-through bypass
module reg_file #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5
) (
  input logic        i_clk,
  input logic        i_rst,
  reg_file_if.slave  bus
);
  localparam int NREG = 1 << ADDR_WIDTH;

  logic [DATA_WIDTH-1:0] regs [NREG];
  logic                  wr_live;

  assign wr_live = bus.i_we && !i_rst && (bus.i_waddr != '0);

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      for (int i = 0; i < NREG; i++) begin
        regs[i] <= '0;
      end
    end else if (wr_live) begin
      regs[bus.i_waddr] <= bus.i_wdata;
    end
  end

  // Address 0 wins over bypass; a live write to the read address is forwarded in the same cycle.
  always_comb begin
    bus.o_rdata1 = regs[bus.i_raddr1];
    if (bus.i_raddr1 == '0) begin
      bus.o_rdata1 = '0;
    end else if (wr_live && (bus.i_raddr1 == bus.i_waddr)) begin
      bus.o_rdata1 = bus.i_wdata;
    end
  end

  always_comb begin
    bus.o_rdata2 = regs[bus.i_raddr2];
    if (bus.i_raddr2 == '0) begin
      bus.o_rdata2 = '0;
    end else if (wr_live && (bus.i_raddr2 == bus.i_waddr)) begin
      bus.o_rdata2 = bus.i_wdata;
    end
  end
endmodule

// File: tb/tb_reg_file.sv
// tb/tb_reg_file.sv - directed bench for reg_file with a reference model checked every cycle
module tb_reg_file;
  logic clk = 1'b0;
  logic rst = 1'b0;
  bit   en  = 1'b0;
  int   n_cmp = 0;
  int   n_bad = 0;
  logic [31:0] mdl [32];

  reg_file_if #(.DATA_WIDTH(32), .ADDR_WIDTH(5)) bus ();

  reg_file #(.DATA_WIDTH(32), .ADDR_WIDTH(5)) dut (
    .i_clk (clk),
    .i_rst (rst),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] val(input int k);
    logic [31:0] kk;
    kk = k;
    if (k == 0) return 32'h0;
    return (k < 16) ? 32'h11111111 * kk : 32'hA5A50000 + kk;
  endfunction

  function automatic logic [31:0] expect_rd(input logic [4:0] ra);
    if (ra == 5'd0) return 32'h0;
    if (bus.i_we && !rst && bus.i_waddr != 5'd0 && bus.i_waddr == ra) return bus.i_wdata;
    return mdl[ra];
  endfunction

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %08h expected %08h at %0t", name, got, exp, $time);
    end
  endtask

  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 32; i++) mdl[i] = 32'h0;
    end else if (bus.i_we && bus.i_waddr != 5'd0) begin
      mdl[bus.i_waddr] = bus.i_wdata;
    end
  end

  always @(negedge clk) begin
    if (en) begin
      check("model_rd1", bus.o_rdata1, expect_rd(bus.i_raddr1));
      check("model_rd2", bus.o_rdata2, expect_rd(bus.i_raddr2));
    end
  end

  task automatic cyc(input logic r, input logic we, input int wa, input logic [31:0] wd,
                     input int ra1, input int ra2);
    @(posedge clk);
    #1;
    rst          = r;
    bus.i_we     = we;
    bus.i_waddr  = wa[4:0];
    bus.i_wdata  = wd;
    bus.i_raddr1 = ra1[4:0];
    bus.i_raddr2 = ra2[4:0];
    #2;
  endtask

  initial begin
    bus.i_we = 1'b0; bus.i_waddr = '0; bus.i_wdata = '0;
    bus.i_raddr1 = '0; bus.i_raddr2 = '0;

    cyc(1'b1, 1'b0, 0, 32'h0, 0, 0);
    for (int k = 0; k < 32; k++) begin
      cyc(1'b0, 1'b0, 0, 32'h0, k, 31 - k);
      en = 1'b1;
      check("reset_sweep_rd1", bus.o_rdata1, 32'h0);
      check("reset_sweep_rd2", bus.o_rdata2, 32'h0);
    end

    for (int k = 1; k < 32; k++) begin
      cyc(1'b0, 1'b1, k, val(k), k, 0);
      check("write_bypass_rd1", bus.o_rdata1, val(k));
    end
    check("pin_val_3", val(3), 32'h33333333);
    check("pin_val_20", val(20), 32'hA5A50014);
    for (int k = 0; k < 31; k++) begin
      cyc(1'b0, 1'b0, 0, 32'h0, k, k + 1);
      check("pair_rd1", bus.o_rdata1, val(k));
      check("pair_rd2", bus.o_rdata2, val(k + 1));
    end
    cyc(1'b0, 1'b0, 0, 32'h0, 9, 9);
    check("same_addr_rd1", bus.o_rdata1, 32'h99999999);
    check("same_addr_rd2", bus.o_rdata2, 32'h99999999);

    cyc(1'b0, 1'b1, 0, 32'hDEADBEEF, 0, 0);
    check("r0_write_rd1", bus.o_rdata1, 32'h0);
    cyc(1'b0, 1'b0, 0, 32'h0, 0, 0);
    check("r0_after_rd1", bus.o_rdata1, 32'h0);
    check("r0_after_rd2", bus.o_rdata2, 32'h0);

    repeat (4) begin
      cyc(1'b0, 1'b0, 5, 32'h12345678, 5, 5);
      check("we_low_hold", bus.o_rdata1, 32'h55555555);
    end

    cyc(1'b0, 1'b1, 7, 32'hCAFEF00D, 7, 8);
    check("bypass_before_edge", bus.o_rdata1, 32'hCAFEF00D);
    check("bypass_other_port", bus.o_rdata2, 32'h88888888);
    cyc(1'b0, 1'b0, 7, 32'h0, 7, 8);
    check("bypass_after_edge", bus.o_rdata1, 32'hCAFEF00D);
    check("bypass_other_after", bus.o_rdata2, 32'h88888888);

    cyc(1'b0, 1'b1, 12, 32'h0BADC0DE, 3, 4);
    check("distinct_rd1", bus.o_rdata1, 32'h33333333);
    check("distinct_rd2", bus.o_rdata2, 32'h44444444);

    cyc(1'b1, 1'b1, 3, 32'hFFFFFFFF, 3, 12);
    check("rst_no_bypass_rd1", bus.o_rdata1, 32'h33333333);
    check("rst_no_bypass_rd2", bus.o_rdata2, 32'h0BADC0DE);
    for (int k = 0; k < 32; k++) begin
      cyc(1'b0, 1'b0, 0, 32'h0, k, (k + 3) % 32);
      check("post_rst_rd1", bus.o_rdata1, 32'h0);
      check("post_rst_rd2", bus.o_rdata2, 32'h0);
    end

    @(posedge clk);
    #1;
    en = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
